// File: rtl/call_return_if.sv
// call_return_if: request, stack and PC-load signals between control unit, call_return_unit and the byte stack.
interface call_return_if;
    logic        call_req;
    logic        ret_req;
    logic [15:0] ret_addr;
    logic [15:0] target;
    logic        stack_push_enable;
    logic [7:0]  stack_push_data;
    logic        stack_pop_enable;
    logic [7:0]  stack_pop_data;
    logic        pc_load;
    logic [15:0] pc_out;
    logic        busy;
    logic [7:0]  depth;
    logic        overflow;
    logic        underflow;

    modport slave (
        input  call_req, ret_req, ret_addr, target, stack_pop_data,
        output stack_push_enable, stack_push_data, stack_pop_enable,
               pc_load, pc_out, busy, depth, overflow, underflow
    );

    modport master (
        output call_req, ret_req, ret_addr, target, stack_pop_data,
        input  stack_push_enable, stack_push_data, stack_pop_enable,
               pc_load, pc_out, busy, depth, overflow, underflow
    );
endinterface

// File: rtl/call_return_unit.sv
// call_return_unit: turns CALL/RET requests into two-byte stack push/pop sequences and a PC-load pulse,
// refusing calls/returns that would overflow or underflow the mirrored stack depth.
module call_return_unit #(
    parameter int CAPACITY = 255
) (
    input logic          clk,
    input logic          rst,
    call_return_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PUSH_LO, PUSH_HI, POP_HI, POP_LO, DONE, FAULT} state_t;

    localparam logic [7:0] MAX_CALL_DEPTH = 8'(CAPACITY - 2);

    state_t      state, next;
    logic [15:0] addr_q, target_q, pc_q;
    logic [7:0]  depth_q, hi_q;
    logic        fault_is_call;

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            addr_q        <= '0;
            target_q      <= '0;
            pc_q          <= '0;
            depth_q       <= '0;
            hi_q          <= '0;
            fault_is_call <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && bus.call_req) begin
                addr_q   <= bus.ret_addr;
                target_q <= bus.target;
            end
            // remembers which request got refused so FAULT can raise the right flag
            if (state == IDLE) fault_is_call <= bus.call_req;
            if (state == PUSH_LO || state == PUSH_HI) depth_q <= depth_q + 8'd1;
            if (state == POP_HI || state == POP_LO) depth_q <= depth_q - 8'd1;
            if (state == POP_HI) hi_q <= bus.stack_pop_data;
            if (state == PUSH_HI) pc_q <= target_q;
            if (state == POP_LO) pc_q <= {hi_q, bus.stack_pop_data};
        end
    end

    always_comb begin
        next = IDLE;
        case (state)
            IDLE:    next = bus.call_req ? (depth_q <= MAX_CALL_DEPTH ? PUSH_LO : FAULT) :
                            bus.ret_req  ? (depth_q >= 8'd2 ? POP_HI : FAULT) : IDLE;
            PUSH_LO: next = PUSH_HI;
            PUSH_HI: next = DONE;
            POP_HI:  next = POP_LO;
            POP_LO:  next = DONE;
            default: next = IDLE;
        endcase
    end

    assign bus.busy              = state != IDLE;
    assign bus.stack_push_enable = state == PUSH_LO || state == PUSH_HI;
    assign bus.stack_push_data   = state == PUSH_LO ? addr_q[7:0] : state == PUSH_HI ? addr_q[15:8] : 8'h00;
    assign bus.stack_pop_enable  = state == POP_HI || state == POP_LO;
    assign bus.pc_load           = state == DONE;
    assign bus.pc_out            = pc_q;
    assign bus.depth             = depth_q;
    assign bus.overflow          = state == FAULT && fault_is_call;
    assign bus.underflow         = state == FAULT && !fault_is_call;
endmodule

// File: tb/tb_call_return_unit.sv
// tb_call_return_unit: directed CALL/RET vectors against a byte-stack model, with a scoreboard monitor
// that checks every strobe, pc_load and fault pulse against queued expectations.
module tb_call_return_unit;
    localparam logic [2:0] K_PUSH = 3'd0, K_POP = 3'd1, K_LOAD = 3'd2, K_OVF = 3'd3, K_UNF = 3'd4;

    typedef struct packed {
        logic [2:0]  kind;
        logic [15:0] val;
        logic [7:0]  dep;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   mdepth = 0;
    logic [15:0] mpc = 16'h0000;
    logic [15:0] mstack[$];

    call_return_if bus ();

    call_return_unit #(.CAPACITY(255)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // byte-wide stack with combinational top-of-stack read, reset together with the DUT
    logic [7:0] mem [0:255];
    int sp = 0;
    always @(posedge clk) begin
        if (rst) sp <= 0;
        else if (bus.stack_push_enable) begin
            mem[sp] <= bus.stack_push_data;
            sp <= sp + 1;
        end else if (bus.stack_pop_enable) sp <= sp - 1;
    end
    assign bus.stack_pop_data = sp > 0 ? mem[sp - 1] : 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2:0] k, input logic [15:0] v, input int d);
        mk.kind = k;
        mk.val  = v;
        mk.dep  = 8'(d);
    endfunction

    always @(negedge clk) begin
        logic [4:0] ev;
        logic [2:0] kind;
        exp_t e;
        ev = {bus.underflow, bus.overflow, bus.pc_load, bus.stack_pop_enable, bus.stack_push_enable};
        if (ev != 5'b0) begin
            kind = ev[0] ? K_PUSH : ev[1] ? K_POP : ev[2] ? K_LOAD : ev[3] ? K_OVF : K_UNF;
            chk("one_event", 32'($countones(ev)), 32'd1);
            if (exp_q.size() == 0) chk("unexpected_event", {29'd0, kind}, 32'hFFFF_FFFF);
            else begin
                e = exp_q.pop_front();
                chk("event_kind", {29'd0, kind}, {29'd0, e.kind});
                chk("event_depth", {24'd0, bus.depth}, {24'd0, e.dep});
                if (kind == K_PUSH) chk("push_data", {24'd0, bus.stack_push_data}, {24'd0, e.val[7:0]});
                if (kind == K_LOAD) chk("pc_out_at_load", {16'd0, bus.pc_out}, {16'd0, e.val});
            end
        end
    end

    task automatic do_req(input logic c, input logic r, input logic [15:0] a, input logic [15:0] t,
                          input int nbusy, input bit glitch);
        @(negedge clk);
        bus.call_req = c;
        bus.ret_req  = r;
        bus.ret_addr = a;
        bus.target   = t;
        @(posedge clk); #1;
        bus.call_req = 1'b0;
        bus.ret_req  = 1'b0;
        for (int i = 1; i <= nbusy; i++) begin
            chk("busy", {31'd0, bus.busy}, 32'd1);
            if (glitch && i == 1) bus.ret_req = 1'b1;
            @(posedge clk); #1;
            bus.ret_req = 1'b0;
        end
        chk("idle", {31'd0, bus.busy}, 32'd0);
        chk("depth", {24'd0, bus.depth}, 32'(mdepth));
        chk("pc_out", {16'd0, bus.pc_out}, {16'd0, mpc});
    endtask

    task automatic do_call(input logic [15:0] a, input logic [15:0] t, input bit both);
        if (mdepth <= 253) begin
            exp_q.push_back(mk(K_PUSH, {8'd0, a[7:0]}, mdepth));
            exp_q.push_back(mk(K_PUSH, {8'd0, a[15:8]}, mdepth + 1));
            exp_q.push_back(mk(K_LOAD, t, mdepth + 2));
            mdepth += 2;
            mstack.push_back(a);
            mpc = t;
            do_req(1'b1, both, a, t, 3, both);
        end else begin
            exp_q.push_back(mk(K_OVF, 16'd0, mdepth));
            do_req(1'b1, 1'b0, a, t, 1, 1'b0);
        end
    endtask

    task automatic do_ret();
        logic [15:0] a;
        if (mdepth >= 2) begin
            a = mstack.pop_back();
            exp_q.push_back(mk(K_POP, 16'd0, mdepth));
            exp_q.push_back(mk(K_POP, 16'd0, mdepth - 1));
            exp_q.push_back(mk(K_LOAD, a, mdepth - 2));
            mdepth -= 2;
            mpc = a;
            do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 3, 1'b0);
        end else begin
            exp_q.push_back(mk(K_UNF, 16'd0, mdepth));
            do_req(1'b0, 1'b1, 16'h0000, 16'h0000, 1, 1'b0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.call_req = 1'b0;
        bus.ret_req  = 1'b0;
        bus.ret_addr = 16'h0000;
        bus.target   = 16'h0000;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_depth", {24'd0, bus.depth}, 32'd0);
        chk("rst_pc_out", {16'd0, bus.pc_out}, 32'd0);
        chk("rst_push_data", {24'd0, bus.stack_push_data}, 32'd0);
        chk("rst_flags", {28'd0, bus.pc_load, bus.overflow, bus.underflow, bus.stack_push_enable}, 32'd0);

        do_call(16'h1234, 16'h0400, 1'b0);
        chk("call_depth2", {24'd0, bus.depth}, 32'd2);
        chk("call_pc0400", {16'd0, bus.pc_out}, 32'h0400);
        do_ret();
        chk("ret_pc1234", {16'd0, bus.pc_out}, 32'h1234);
        chk("ret_depth0", {24'd0, bus.depth}, 32'd0);
        do_ret();
        chk("unf_pc_kept", {16'd0, bus.pc_out}, 32'h1234);

        do_call(16'h5678, 16'h0800, 1'b1);
        chk("both_pc0800", {16'd0, bus.pc_out}, 32'h0800);
        do_ret();
        chk("both_ret_pc", {16'd0, bus.pc_out}, 32'h5678);

        for (int i = 0; i < 126; i++) do_call(16'h1000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
        chk("depth252", {24'd0, bus.depth}, 32'd252);
        do_call(16'h107E, 16'h207E, 1'b0);
        chk("depth254", {24'd0, bus.depth}, 32'd254);
        do_call(16'hDEAD, 16'hBEEF, 1'b0);
        chk("ovf_depth254", {24'd0, bus.depth}, 32'd254);
        chk("ovf_pc_kept", {16'd0, bus.pc_out}, 32'h207E);
        do_ret();
        chk("lifo_pc", {16'd0, bus.pc_out}, 32'h107E);
        do_ret();
        chk("lifo_pc2", {16'd0, bus.pc_out}, 32'h107D);

        // reset lands while the high byte is being pushed; no pc_load may follow
        exp_q.push_back(mk(K_PUSH, 16'h00CD, mdepth));
        exp_q.push_back(mk(K_PUSH, 16'h00AB, mdepth + 1));
        @(negedge clk);
        bus.call_req = 1'b1;
        bus.ret_addr = 16'hABCD;
        bus.target   = 16'h0C00;
        @(posedge clk); #1;
        bus.call_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mdepth = 0;
        mpc = 16'h0000;
        mstack.delete();
        chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mid_rst_depth", {24'd0, bus.depth}, 32'd0);
        chk("mid_rst_pc_out", {16'd0, bus.pc_out}, 32'd0);
        chk("mid_rst_strobes", {29'd0, bus.pc_load, bus.stack_push_enable, bus.stack_pop_enable}, 32'd0);
        repeat (4) @(posedge clk);
        do_call(16'h4321, 16'h0100, 1'b0);
        chk("post_rst_pc", {16'd0, bus.pc_out}, 32'h0100);

        repeat (3) @(posedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
